// File: rtl/sa_ctrl_pkg.sv
// Shared types and defaults for the systolic-array tile sequencer.
// Holds the phase enum and the row-index width helper.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_FILL,
        S_DRAIN,
        S_FLUSH
    } sa_state_t;

    localparam int SA_ROWS_DEF     = 32;
    localparam int FILL_LAT_DEF    = 16;
    localparam int POST_STAGES_DEF = 2;

    // Row index width: at least one bit even for a two-row array.
    function automatic int ridx_w(input int rows);
        return (rows > 2) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/sa_post_pipe.sv
// Post-processing pipeline delay chain for the tile sequencer.
// Stage 0 follows its inputs directly; each later stage is one register behind.
module sa_post_pipe #(
    parameter int POST_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_i,
    input  logic                   rst_i,
    input  logic                   last_i,
    output logic [POST_STAGES-1:0] post_en_o,
    output logic [POST_STAGES-1:0] post_reset_o,
    output logic                   post_last_o
);

    logic [POST_STAGES-1:0] last_q;

    // Last-row marker shifted through the full pipeline depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '0;
        end else begin
            last_q <= POST_STAGES'({last_q, last_i});
        end
    end

    assign post_last_o = last_q[POST_STAGES-1];

    if (POST_STAGES == 1) begin : g_single
        assign post_en_o    = en_i;
        assign post_reset_o = rst_i;
    end else begin : g_chain
        logic [POST_STAGES-2:0] en_q;
        logic [POST_STAGES-2:0] rst_q;

        // Enable and reset each trail the previous stage by one cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                en_q  <= '0;
                rst_q <= '0;
            end else begin
                en_q  <= (POST_STAGES-1)'({en_q, en_i});
                rst_q <= (POST_STAGES-1)'({rst_q, rst_i});
            end
        end

        assign post_en_o    = {en_q, en_i};
        assign post_reset_o = {rst_q, rst_i};
    end

endmodule

// File: rtl/sa_tile_ctrl.sv
// Tile sequencer for the systolic array: feed, fill, drain and flush phases.
// Drives SA enables, accumulator clear, drain row index and post-pipe controls.
module sa_tile_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int SA_ROWS     = SA_ROWS_DEF,
    parameter int FILL_LAT    = FILL_LAT_DEF,
    parameter int POST_STAGES = POST_STAGES_DEF,
    parameter int CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic                       start,
    input  logic [CNT_W-1:0]           nif_k2,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       sa_en,
    output logic                       sa_reset,
    output logic                       acc_clear,
    output logic                       drain_en,
    output logic [ridx_w(SA_ROWS)-1:0] drain_row_idx,
    output logic [POST_STAGES-1:0]     post_en,
    output logic [POST_STAGES-1:0]     post_reset,
    output logic                       post_last,
    output logic                       mult_array_mode
);

    localparam int RIDX_W = ridx_w(SA_ROWS);
    localparam int FILL_W = $clog2(FILL_LAT + 1);

    localparam logic [RIDX_W-1:0] ROW_LAST  = RIDX_W'(SA_ROWS - 1);
    localparam logic [RIDX_W-1:0] ROW_ONE   = RIDX_W'(1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_LAT - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  PIX_ONE   = CNT_W'(1);

    sa_state_t         state_q;
    logic [CNT_W-1:0]  nif_q;
    logic [CNT_W-1:0]  pix_cnt_q;
    logic [FILL_W-1:0] fill_cnt_q;
    logic [RIDX_W-1:0] row_cnt_q;
    logic              acc_rst_q;
    logic              sa_reset_q;
    logic              drain_acc;
    logic              last_acc;

    // A row is handed downstream only when the consumer is ready.
    assign drain_acc = (state_q == S_DRAIN) && out_ready;
    assign last_acc  = drain_acc && (row_cnt_q == ROW_LAST);

    // Phase sequencing with its counters; each counter clears on phase exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            nif_q      <= '0;
            pix_cnt_q  <= '0;
            fill_cnt_q <= '0;
            row_cnt_q  <= '0;
            acc_rst_q  <= 1'b1;
            sa_reset_q <= 1'b0;
        end else begin
            acc_rst_q  <= 1'b0;
            sa_reset_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nif_q     <= nif_k2;
                        pix_cnt_q <= '0;
                        state_q   <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (pix_cnt_q == nif_q) begin
                        pix_cnt_q <= '0;
                        state_q   <= S_FILL;
                    end else begin
                        pix_cnt_q <= pix_cnt_q + PIX_ONE;
                    end
                end
                S_FILL: begin
                    if (fill_cnt_q == FILL_LAST) begin
                        fill_cnt_q <= '0;
                        state_q    <= S_DRAIN;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + FILL_ONE;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (row_cnt_q == ROW_LAST) begin
                            row_cnt_q  <= '0;
                            sa_reset_q <= 1'b1;
                            state_q    <= S_FLUSH;
                        end else begin
                            row_cnt_q <= row_cnt_q + ROW_ONE;
                        end
                    end
                end
                S_FLUSH: begin
                    if (post_last) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    sa_post_pipe #(
        .POST_STAGES (POST_STAGES)
    ) u_post (
        .clk          (clk),
        .reset        (reset),
        .en_i         (drain_acc),
        .rst_i        (sa_reset_q),
        .last_i       (last_acc),
        .post_en_o    (post_en),
        .post_reset_o (post_reset),
        .post_last_o  (post_last)
    );

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_FLUSH) && post_last;
    assign sa_en           = (state_q == S_FEED) || (state_q == S_FILL) || drain_acc;
    assign sa_reset        = sa_reset_q;
    assign acc_clear       = reset || acc_rst_q
                           || ((state_q == S_FILL) && (fill_cnt_q == '0));
    assign drain_en        = drain_acc;
    assign drain_row_idx   = drain_acc ? row_cnt_q : '0;
    assign mult_array_mode = mode && post_en[0];

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Bench for sa_tile_ctrl: directed and random tiles on two configurations.
// Expected cycle timelines come from phase arithmetic and the ready pattern.
module tb_sa_tile_ctrl;

    localparam int MAXC = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] nif_k2 = '0;

    always #5 clk = ~clk;

    logic       a_busy, a_done, a_sa_en, a_sa_reset, a_acc_clear;
    logic       a_drain_en, a_post_last, a_mma;
    logic [4:0] a_idx;
    logic [1:0] a_pen, a_prst;

    logic       b_busy, b_done, b_sa_en, b_sa_reset, b_acc_clear;
    logic       b_drain_en, b_post_last, b_mma;
    logic [1:0] b_idx;
    logic [0:0] b_pen, b_prst;

    sa_tile_ctrl u_a (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .start           (start),
        .nif_k2          (nif_k2),
        .out_ready       (out_ready),
        .busy            (a_busy),
        .done            (a_done),
        .sa_en           (a_sa_en),
        .sa_reset        (a_sa_reset),
        .acc_clear       (a_acc_clear),
        .drain_en        (a_drain_en),
        .drain_row_idx   (a_idx),
        .post_en         (a_pen),
        .post_reset      (a_prst),
        .post_last       (a_post_last),
        .mult_array_mode (a_mma)
    );

    sa_tile_ctrl #(
        .SA_ROWS     (4),
        .FILL_LAT    (1),
        .POST_STAGES (1),
        .CNT_W       (32)
    ) u_b (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .start           (start),
        .nif_k2          (nif_k2),
        .out_ready       (out_ready),
        .busy            (b_busy),
        .done            (b_done),
        .sa_en           (b_sa_en),
        .sa_reset        (b_sa_reset),
        .acc_clear       (b_acc_clear),
        .drain_en        (b_drain_en),
        .drain_row_idx   (b_idx),
        .post_en         (b_pen),
        .post_reset      (b_prst),
        .post_last       (b_post_last),
        .mult_array_mode (b_mma)
    );

    bit         sel = 1'b0;
    logic [4:0] o_ctl;
    logic [5:0] o_drn;
    logic [4:0] o_pst;
    logic       o_mma;

    always_comb begin
        if (sel) begin
            o_ctl = {b_busy, b_done, b_sa_en, b_sa_reset, b_acc_clear};
            o_drn = {b_drain_en, 3'b000, b_idx};
            o_pst = {1'b0, b_pen, 1'b0, b_prst, b_post_last};
            o_mma = b_mma;
        end else begin
            o_ctl = {a_busy, a_done, a_sa_en, a_sa_reset, a_acc_clear};
            o_drn = {a_drain_en, a_idx};
            o_pst = {a_pen, a_prst, a_post_last};
            o_mma = a_mma;
        end
    end

    int cfg_r = 32;
    int cfg_f = 16;
    int cfg_p = 2;
    int end_c;
    int n_chk = 0;
    int n_fail = 0;
    bit rdy [MAXC];
    bit st  [MAXC];
    bit den [MAXC];
    int eidx[MAXC];

    task automatic chk(input string tag, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic set_all();
        for (int i = 0; i < MAXC; i++) begin
            rdy[i] = 1'b1;
            st[i]  = 1'b0;
        end
    endtask

    task automatic set_rand(input int n);
        for (int i = 0; i < MAXC; i++) begin
            rdy[i] = ($urandom_range(0, 3) != 0);
            st[i]  = (i >= 1) && (i <= n + 1) && ($urandom_range(0, 7) == 0);
        end
    endtask

    // Walk the drain from its first cycle, accepting a row on every ready cycle.
    task automatic build_model(input int n);
        int r;
        int c;
        for (int i = 0; i < MAXC; i++) begin
            den[i]  = 1'b0;
            eidx[i] = 0;
        end
        r     = 0;
        c     = n + 2 + cfg_f;
        end_c = MAXC - 10;
        while (r < cfg_r && c < MAXC - 10) begin
            if (rdy[c]) begin
                den[c]  = 1'b1;
                eidx[c] = r;
                r++;
                if (r == cfg_r) end_c = c;
            end
            c++;
        end
    endtask

    task automatic run_tile(input int n, input bit m, input bit do_rst,
                            input int abort_c, output int done_seen);
        int         last_c;
        int         dexp;
        bit         e_busy, e_done, e_sae, e_sar, e_acc, e_mma;
        int         e_idx;
        logic [1:0] e_pen, e_prst;
        build_model(n);
        dexp      = (abort_c >= 0) ? -1 : end_c + cfg_p;
        last_c    = (abort_c >= 0) ? abort_c + 4 : end_c + cfg_p + 3;
        done_seen = -1;
        if (do_rst) begin
            reset     = 1'b1;
            start     = 1'b0;
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("rst_ctl", 0, 32'(o_ctl), 32'h1);
            chk("rst_drn", 0, 32'(o_drn), 32'h0);
            chk("rst_pst", 0, 32'(o_pst), 32'h0);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mode      = m;
        nif_k2    = n;
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("c0_ctl", 0, 32'(o_ctl), 32'(do_rst));
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            out_ready = rdy[c];
            start     = st[c];
            reset     = (c == abort_c);
            @(negedge clk);
            if (o_ctl[3] && done_seen < 0) done_seen = c;
            e_pen  = '0;
            e_prst = '0;
            for (int i = 0; i < cfg_p; i++) begin
                if (c - i >= 0) e_pen[i] = den[c - i];
                e_prst[i] = (c == end_c + 1 + i);
            end
            e_busy = (c <= end_c + cfg_p);
            e_done = (c == end_c + cfg_p);
            e_sae  = (c <= n + 1 + cfg_f) || den[c];
            e_sar  = (c == end_c + 1);
            e_acc  = (c == n + 2);
            e_idx  = den[c] ? eidx[c] : 0;
            e_mma  = m && den[c];
            if (abort_c >= 0) begin
                if (c == abort_c) e_acc = 1'b1;
                if (c > abort_c) begin
                    e_busy = 1'b0;
                    e_done = 1'b0;
                    e_sae  = 1'b0;
                    e_sar  = 1'b0;
                    e_acc  = (c == abort_c + 1);
                    e_idx  = 0;
                    e_mma  = 1'b0;
                    e_pen  = '0;
                    e_prst = '0;
                end
            end
            chk("ctl", c, 32'(o_ctl),
                32'({e_busy, e_done, e_sae, e_sar, e_acc}));
            chk("drain", c, 32'(o_drn),
                32'({(e_idx != 0) || (den[c] && !(abort_c >= 0 && c > abort_c)), 5'(e_idx)}));
            chk("post", c, 32'(o_pst), 32'({e_pen, e_prst, e_done}));
            chk("mma", c, 32'(o_mma), 32'(e_mma));
        end
        reset = 1'b0;
        start = 1'b0;
        chk("done_cycle", last_c, done_seen, dexp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        sel   = 1'b0;
        cfg_r = 32;
        cfg_f = 16;
        cfg_p = 2;

        set_all();
        run_tile(3, 1'b1, 1'b1, -1, d);
        chk("nominal_done", 0, d, 54);

        set_all();
        run_tile(3, 1'b0, 1'b1, -1, d);
        chk("mode0_done", 0, d, 54);

        set_all();
        rdy[31] = 1'b0;
        rdy[32] = 1'b0;
        rdy[33] = 1'b0;
        run_tile(3, 1'b1, 1'b1, -1, d);
        chk("backpressure_done", 0, d, 57);

        set_all();
        st[2]  = 1'b1;
        st[25] = 1'b1;
        st[54] = 1'b1;
        run_tile(3, 1'b1, 1'b1, -1, d);
        chk("collision_done", 0, d, 54);

        set_all();
        run_tile(3, 1'b1, 1'b1, 26, d);
        set_all();
        run_tile(3, 1'b1, 1'b0, -1, d);
        chk("after_abort_done", 0, d, 54);

        repeat (4) begin
            int n;
            n = $urandom_range(0, 8);
            set_rand(n);
            run_tile(n, 1'($urandom_range(0, 1)), 1'b1, -1, d);
        end

        sel   = 1'b1;
        cfg_r = 4;
        cfg_f = 1;
        cfg_p = 1;

        set_all();
        run_tile(0, 1'b1, 1'b1, -1, d);
        chk("min_done", 0, d, 7);

        repeat (6) begin
            int n;
            n = $urandom_range(0, 8);
            set_rand(n);
            run_tile(n, 1'($urandom_range(0, 1)), 1'b1, -1, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_tile_ctrl.md
# sa_tile_ctrl

Parametrised tile sequencer for the systolic-array (SA) datapath, the next generation of the fixed 32-row controller. For one tile it runs the SA feed, pipeline fill, output-channel drain and post-processing flush phases. It drives the per-stage enables and resets of the post pipeline (bias, e-tail, quantify, …), whose depth is now a parameter. Added over the previous generation: start/busy/done handshake, `out_ready` back-pressure on the drain, and configurable rows, fill latency and post depth.

## Interface
- `SA_ROWS`, 32: output channels drained per tile; must be ≥2.
- `FILL_LAT`, 16: cycles between the last feed word and the first drained row; must be ≥1.
- `POST_STAGES`, 2: post-processing pipeline depth; must be ≥1.
- `CNT_W`, 32: width of the pixel-word count.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `mode` in 1: layer mode; gates `mult_array_mode`.
- `start` in 1: one-cycle tile request. Honoured only in IDLE.
- `nif_k2` in CNT_W: feed words per tile minus 1 (nif·k·k − 1). Sampled on the accepted `start`.
- `out_ready` in 1: downstream can accept one drained row this cycle.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse on the last FLUSH cycle.
- `sa_en` out 1: SA shift/MAC enable.
- `sa_reset` out 1: one-cycle SA clear after the drain.
- `acc_clear` out 1: output-channel accumulator clear.
- `drain_en` out 1: a row is presented this cycle.
- `drain_row_idx` out RIDX_W=max(1,$clog2(SA_ROWS)): row being drained; 0 when `drain_en`=0.
- `post_en` out POST_STAGES: per-stage enable; bit 0 is the first stage (bias).
- `post_reset` out POST_STAGES: per-stage one-cycle reset after the tile's last row.
- `post_last` out 1: marks the tile's last row leaving the final post stage.
- `mult_array_mode` out 1: `mode` && `post_en[0]`.

## Operation
- The FSM has five states: IDLE → FEED → FILL → DRAIN → FLUSH → IDLE.
- **IDLE:** an accepted `start` latches `nif_k2` and moves to FEED. `start` in any other state, including the `done` cycle, is ignored.
- **FEED:** `pix_cnt` counts from 0 to the latched `nif_k2`, so the phase lasts `nif_k2`+1 cycles. `sa_en`=1. When `pix_cnt` equals `nif_k2`, the FSM moves to FILL.
- **FILL:** `acc_clear`=1 on the first FILL cycle only. `sa_en`=1. `fill_cnt` runs for FILL_LAT cycles, then the FSM moves to DRAIN.
- **DRAIN:**
  - `drain_en` = `out_ready`.
  - `sa_en` = `out_ready`, so a stall freezes the array.
  - `row_cnt` advances only when `out_ready`=1.
  - After row SA_ROWS−1 is accepted, the FSM moves to FLUSH.
- **FLUSH:**
  - `sa_en`=0.
  - `sa_reset`=1 on the first FLUSH cycle.
  - The phase lasts POST_STAGES cycles, and `done` is asserted on its last cycle.
- **Post pipeline:**
  - `post_en[0]` = `drain_en`; `post_en[i]` = `post_en[i-1]` registered.
  - `post_reset[0]` pulses on the first FLUSH cycle; `post_reset[i]` is `post_reset[i-1]` registered.
  - `post_last` is "last row accepted" delayed by POST_STAGES cycles.
- **Counter widths:** `pix_cnt` is CNT_W bits; `row_cnt` is RIDX_W bits; `fill_cnt` is $clog2(FILL_LAT+1) bits. None of them wraps: each is cleared on its phase exit.
- **Reset values:**
  - `acc_clear`=1 during reset and on the first cycle after reset deasserts, then 0.
  - All other outputs are 0 and the state is IDLE.
- **Reset mid-tile:** abandons the tile with no `done`, clears the post chain, and returns to IDLE on the next edge.

## Timing
- Let N = `nif_k2`, with `start` sampled at edge 0 and `out_ready` held at 1:
  - FEED occupies cycles 1..N+1.
  - FILL occupies cycles N+2..N+1+FILL_LAT, with `acc_clear` at N+2.
  - DRAIN occupies the next SA_ROWS cycles, with `drain_row_idx` running 0..SA_ROWS−1.
  - `sa_reset` and `post_reset[0]` assert at cycle N+2+FILL_LAT+SA_ROWS.
  - `done` and `post_last` assert together at cycle N+1+FILL_LAT+SA_ROWS+POST_STAGES.
- Each `out_ready`=0 cycle during DRAIN adds exactly one cycle to the drain and to all later events.
- `out_ready` is not observed outside DRAIN.
- Latency from `start` to `busy`: 1 cycle. `busy` falls on the cycle after `done`.

## Structure
- Package `sa_ctrl_pkg` holds:
  - the state enum typedef `sa_state_t`;
  - default constants `SA_ROWS_DEF`, `FILL_LAT_DEF`, `POST_STAGES_DEF`;
  - the RIDX_W helper function.
- Sub-module `sa_post_pipe` (parameter POST_STAGES) contains the registered delay chain for `post_en`, `post_reset` and `post_last`.
- The FSM and the three counters stay in the top module.

## Test plan
- **Nominal tile.** Defaults, N=3, `out_ready`=1, `start` at 0. Required: `acc_clear` at 5; `drain_row_idx` runs 0..31 on cycles 21..52; `sa_reset` at 53; `done` and `post_last` at 54; `busy` over 1..54.
- **Back-pressure.** Same as nominal, with `out_ready`=0 for 3 cycles while row 10 is presented. Required: row 10 is held with `drain_en`=0 and `sa_en`=0; `done` moves to 57; no row is skipped or repeated.
- **Minimum tile.** N=0, SA_ROWS=4, FILL_LAT=1, POST_STAGES=1. Required: FEED is 1 cycle; `done` at 7.
- **Start collision.** `start` pulses during FEED, during DRAIN and on the `done` cycle. Required: all three are ignored, and the timing of the running tile is unchanged.
- **Reset mid-tile.** Assert `reset` in DRAIN at row 5. Required: the next cycle is IDLE; `drain_en`, `sa_en`, `post_en` and `busy` are 0 and `acc_clear`=1; no `done`. A new `start` then completes the nominal timing.
- **Mode gating.** `mode`=1 versus `mode`=0 on a nominal tile. Required: `mult_array_mode` equals `post_en[0]` (high on cycles 21..52) when `mode`=1, and stays 0 when `mode`=0.
